// File: rtl/astropix_frame_packet_buffer.sv
// Packet-mode byte FIFO: frames are held until fully received and length
// checked, then released whole; malformed or oversized frames are dropped.
module astropix_frame_packet_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH_LOG2 = 10,
  parameter int                    DEST_WIDTH = 8,
  parameter logic [DEST_WIDTH-1:0] DEST_ID    = '0,
  parameter int                    MIN_LEN    = 6,
  parameter int                    MAX_LEN    = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  input  logic                  cfg_flush,
  output logic                  stat_frame_committed,
  output logic                  stat_frame_dropped,
  output logic                  stat_length_error,
  output logic [DEPTH_LOG2:0]   status_frames_stored,
  output logic                  status_full
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] MINL = 32'(MIN_LEN);
  localparam logic [31:0] MAXL = 32'(MAX_LEN);

  typedef enum logic [1:0] {
    W_LEN,
    W_BODY,
    W_DISCARD
  } wstate_t;

  wstate_t state, state_n;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0]         wr_ptr_n, commit_ptr_n;
  logic [PW-1:0]         free;
  logic [DATA_WIDTH-1:0] rem, rem_n;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid, out_last;
  logic [PW-1:0]         frames;
  logic                  rdy;
  logic                  in_hs, out_hs, load, has_data;
  logic                  wr_en, commit, drop, len_err;
  logic                  len_bad, last_slot;
  logic [31:0]           need;

  assign s_axis_tready        = rdy;
  assign m_axis_tdata         = out_data;
  assign m_axis_tvalid        = out_valid;
  assign m_axis_tlast         = out_last;
  assign m_axis_tdest         = DEST_ID;
  assign status_frames_stored = frames;

  // free counts the output register's byte as released from memory
  assign free        = PW'(DEPTH) - (wr_ptr - rd_ptr);
  assign status_full = 32'(free) < (MAXL + 32'd1);

  assign in_hs     = s_axis_tvalid && rdy;
  assign need      = 32'(s_axis_tdata) + 32'd1;
  assign len_bad   = (32'(s_axis_tdata) < MINL) ||
                     (32'(s_axis_tdata) > MAXL);
  assign last_slot = rem == DATA_WIDTH'(1);

  assign has_data = rd_ptr != commit_ptr;
  assign out_hs   = out_valid && m_axis_tready;
  assign load     = has_data && (!out_valid || m_axis_tready);

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    rem_n        = rem;
    wr_en        = 1'b0;
    commit       = 1'b0;
    drop         = 1'b0;
    len_err      = 1'b0;
    if (in_hs) begin
      case (state)
        W_LEN: begin
          if (s_axis_tlast || len_bad) begin
            len_err = 1'b1;
            state_n = s_axis_tlast ? W_LEN : W_DISCARD;
          end else if (32'(free) < need) begin
            drop    = 1'b1;
            state_n = W_DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + PW'(1);
            rem_n    = s_axis_tdata;
            state_n  = W_BODY;
          end
        end
        W_BODY: begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + PW'(1);
          rem_n    = rem - DATA_WIDTH'(1);
          if (last_slot && s_axis_tlast) begin
            commit       = 1'b1;
            commit_ptr_n = wr_ptr + PW'(1);
            state_n      = W_LEN;
          end else if (last_slot || s_axis_tlast) begin
            len_err  = 1'b1;
            wr_ptr_n = commit_ptr;
            state_n  = s_axis_tlast ? W_LEN : W_DISCARD;
          end
        end
        W_DISCARD: begin
          if (s_axis_tlast) state_n = W_LEN;
        end
        default: state_n = W_LEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= W_LEN;
      wr_ptr               <= '0;
      commit_ptr           <= '0;
      rd_ptr               <= '0;
      rem                  <= '0;
      frames               <= '0;
      rdy                  <= 1'b0;
      out_valid            <= 1'b0;
      out_last             <= 1'b0;
      out_data             <= '0;
      stat_frame_committed <= 1'b0;
      stat_frame_dropped   <= 1'b0;
      stat_length_error    <= 1'b0;
    end else if (cfg_flush) begin
      state                <= (state == W_BODY) ? W_DISCARD : W_LEN;
      wr_ptr               <= '0;
      commit_ptr           <= '0;
      rd_ptr               <= '0;
      frames               <= '0;
      rdy                  <= 1'b1;
      out_valid            <= 1'b0;
      stat_frame_committed <= 1'b0;
      stat_frame_dropped   <= 1'b0;
      stat_length_error    <= 1'b0;
    end else begin
      state                <= state_n;
      wr_ptr               <= wr_ptr_n;
      commit_ptr           <= commit_ptr_n;
      rem                  <= rem_n;
      rdy                  <= 1'b1;
      stat_frame_committed <= commit;
      stat_frame_dropped   <= drop;
      stat_length_error    <= len_err;
      if (load) begin
        out_data  <= mem[rd_ptr[DEPTH_LOG2-1:0]][DATA_WIDTH-1:0];
        out_last  <= mem[rd_ptr[DEPTH_LOG2-1:0]][DATA_WIDTH];
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + PW'(1);
      end else if (m_axis_tready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case ({commit, out_hs && out_last})
        2'b10:   frames <= frames + PW'(1);
        2'b01:   frames <= frames - PW'(1);
        default: frames <= frames;
      endcase
    end
  end

endmodule

// File: tb/tb_astropix_frame_packet_buffer.sv
// Randomised bench for astropix_frame_packet_buffer against a queue-based
// frame model, with literal expectations for the directed scenarios.
module tb_astropix_frame_packet_buffer;

  localparam int DL    = 5;
  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic [7:0] m_axis_tdest;
  logic       cfg_flush = 1'b0;
  logic       stat_frame_committed;
  logic       stat_frame_dropped;
  logic       stat_length_error;
  logic [DL:0] status_frames_stored;
  logic       status_full;

  always #5 clk = ~clk;

  astropix_frame_packet_buffer #(
    .DATA_WIDTH(8),
    .DEPTH_LOG2(DL),
    .DEST_WIDTH(8),
    .DEST_ID(8'h00),
    .MIN_LEN(6),
    .MAX_LEN(13)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest),
    .cfg_flush(cfg_flush),
    .stat_frame_committed(stat_frame_committed),
    .stat_frame_dropped(stat_frame_dropped),
    .stat_length_error(stat_length_error),
    .status_frames_stored(status_frames_stored),
    .status_full(status_full)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: committed bytes wait in mq, the frame being received
  // sits in pq, and a single output slot holds the presented byte.
  typedef enum {M_LEN, M_BODY, M_DISC} mst_t;
  logic [8:0] mq[$];
  logic [8:0] pq[$];
  bit         m_oval = 0;
  logic [7:0] m_odata = '0;
  bit         m_olast = 0;
  int         m_frames = 0;
  bit         m_rdy = 0;
  bit         m_cmt = 0, m_drp = 0, m_lerr = 0;
  mst_t       m_st = M_LEN;
  int         m_rem = 0;
  bit         started = 0;

  always @(posedge clk) begin
    logic [8:0] w;
    int fr;
    bit ih, oh, ol;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      pq.delete();
      m_oval = 0;
      m_olast = 0;
      m_frames = 0;
      m_rdy = 0;
      m_cmt = 0;
      m_drp = 0;
      m_lerr = 0;
      m_st = M_LEN;
      m_rem = 0;
    end else begin
      ih = s_axis_tvalid && m_rdy;
      oh = m_oval && m_axis_tready;
      ol = m_olast;
      m_rdy = 1;
      m_cmt = 0;
      m_drp = 0;
      m_lerr = 0;
      if (cfg_flush) begin
        mq.delete();
        pq.delete();
        m_oval = 0;
        m_frames = 0;
        m_st = (m_st == M_BODY) ? M_DISC : M_LEN;
      end else begin
        fr = DEPTH - pq.size() - mq.size();
        if (!m_oval || m_axis_tready) begin
          if (mq.size() != 0) begin
            w = mq.pop_front();
            m_odata = w[7:0];
            m_olast = w[8];
            m_oval = 1;
          end else begin
            m_oval = 0;
          end
        end
        if (oh && ol) m_frames--;
        if (ih) begin
          case (m_st)
            M_LEN: begin
              if (s_axis_tlast || s_axis_tdata < 6 || s_axis_tdata > 13) begin
                m_lerr = 1;
                m_st = s_axis_tlast ? M_LEN : M_DISC;
              end else if (fr < int'(s_axis_tdata) + 1) begin
                m_drp = 1;
                m_st = M_DISC;
              end else begin
                pq.push_back({1'b0, s_axis_tdata});
                m_rem = int'(s_axis_tdata);
                m_st = M_BODY;
              end
            end
            M_BODY: begin
              pq.push_back({s_axis_tlast, s_axis_tdata});
              if (m_rem == 1 && s_axis_tlast) begin
                foreach (pq[i]) mq.push_back(pq[i]);
                pq.delete();
                m_frames++;
                m_cmt = 1;
                m_st = M_LEN;
              end else if (m_rem == 1 || s_axis_tlast) begin
                pq.delete();
                m_lerr = 1;
                m_st = s_axis_tlast ? M_LEN : M_DISC;
              end else begin
                m_rem--;
              end
            end
            default: if (s_axis_tlast) m_st = M_LEN;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("s_tready", 32'(s_axis_tready), 32'(m_rdy));
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(m_oval));
      if (m_oval) begin
        chk("m_tdata", 32'(m_axis_tdata), 32'(m_odata));
        chk("m_tlast", 32'(m_axis_tlast), 32'(m_olast));
      end
      chk("m_tdest", 32'(m_axis_tdest), 32'h00);
      chk("stat_commit", 32'(stat_frame_committed), 32'(m_cmt));
      chk("stat_drop", 32'(stat_frame_dropped), 32'(m_drp));
      chk("stat_lerr", 32'(stat_length_error), 32'(m_lerr));
      chk("frames_stored", 32'(status_frames_stored), 32'(m_frames));
      chk("full", 32'(status_full),
          32'((DEPTH - pq.size() - mq.size()) < 14));
    end
  end

  int n_out = 0, n_cmt = 0, n_drp = 0, n_lerr = 0;
  logic [8:0] cap[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        cap.push_back({m_axis_tlast, m_axis_tdata});
      end
      if (stat_frame_committed) n_cmt++;
      if (stat_frame_dropped) n_drp++;
      if (stat_length_error) n_lerr++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tlast = l;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit rnd);
    send_byte(8'(len), 1'b0);
    for (int i = 1; i <= len; i++) begin
      if (rnd) begin
        m_axis_tready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0) idle(1);
        m_axis_tready = ($urandom_range(0, 3) != 0);
      end
      send_byte(8'($urandom), i == len);
    end
  endtask

  logic [7:0] f1 [9] = '{8'h08, 8'h03, 8'h02, 8'hD0, 8'hD1,
                         8'hA0, 8'hA1, 8'hA2, 8'hA3};

  int b_out, b_cmt, b_drp, b_lerr, b_cap;

  task automatic snap();
    b_out = n_out;
    b_cmt = n_cmt;
    b_drp = n_drp;
    b_lerr = n_lerr;
    b_cap = cap.size();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_frames", 32'(status_frames_stored), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // single frame, latency and content
    m_axis_tready = 1'b1;
    snap();
    for (int i = 0; i < 9; i++) send_byte(f1[i], i == 8);
    @(negedge clk);
    chk("t1_tvalid_1cyc", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    chk("t1_tvalid_2cyc", 32'(m_axis_tvalid), 32'd1);
    idle(14);
    chk("t1_bytes", 32'(n_out - b_out), 32'd9);
    chk("t1_commits", 32'(n_cmt - b_cmt), 32'd1);
    for (int i = 0; i < 9; i++)
      chk("t1_byte", 32'(cap[b_cap + i]), 32'({i == 8, f1[i]}));

    // fill with output stalled
    m_axis_tready = 1'b0;
    snap();
    repeat (4) send_frame(8, 1'b0);
    idle(2);
    chk("t2_drops", 32'(n_drp - b_drp), 32'd1);
    chk("t2_commits", 32'(n_cmt - b_cmt), 32'd3);
    chk("t2_stored", 32'(status_frames_stored), 32'd3);
    chk("t2_tready", 32'(s_axis_tready), 32'd1);
    chk("t2_full", 32'(status_full), 32'd1);
    m_axis_tready = 1'b1;
    idle(40);
    chk("t2_bytes", 32'(n_out - b_out), 32'd27);
    chk("t2_stored_end", 32'(status_frames_stored), 32'd0);

    // early tlast
    snap();
    send_byte(8'h08, 1'b0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    send_frame(8, 1'b0);
    idle(14);
    chk("t3_lerr", 32'(n_lerr - b_lerr), 32'd1);
    chk("t3_bytes", 32'(n_out - b_out), 32'd9);

    // undersized length byte
    snap();
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_frame(6, 1'b0);
    idle(12);
    chk("t4_lerr", 32'(n_lerr - b_lerr), 32'd1);
    chk("t4_bytes", 32'(n_out - b_out), 32'd7);
    chk("t4_commits", 32'(n_cmt - b_cmt), 32'd1);

    // random traffic, pointer wrap
    snap();
    for (int f = 0; f < 20; f++) send_frame($urandom_range(6, 13), 1'b1);
    m_axis_tready = 1'b1;
    idle(60);
    chk("t5_frames", 32'(n_cmt - b_cmt + n_drp - b_drp), 32'd20);
    chk("t5_wrap", 32'(n_out - b_out >= 64), 32'd1);
    chk("t5_stored_end", 32'(status_frames_stored), 32'd0);

    // flush mid-frame with a frame pending
    m_axis_tready = 1'b0;
    send_frame(7, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    cfg_flush = 1'b1;
    idle(1);
    cfg_flush = 1'b0;
    @(negedge clk);
    chk("fl_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("fl_stored", 32'(status_frames_stored), 32'd0);
    @(posedge clk);
    #1;
    snap();
    for (int i = 0; i < 6; i++) send_byte(8'(i), i == 5);
    m_axis_tready = 1'b1;
    send_frame(8, 1'b0);
    idle(14);
    chk("fl_bytes", 32'(n_out - b_out), 32'd9);
    chk("fl_commits", 32'(n_cmt - b_cmt), 32'd1);

    // reset mid-frame with a frame pending
    m_axis_tready = 1'b0;
    send_frame(6, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h09 : 8'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("r6_stored", 32'(status_frames_stored), 32'd0);
    chk("r6_pulses", 32'({stat_frame_committed, stat_frame_dropped,
                          stat_length_error}), 32'd0);
    idle(2);
    snap();
    m_axis_tready = 1'b1;
    send_frame(10, 1'b0);
    idle(16);
    chk("r6_bytes", 32'(n_out - b_out), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
